// File: rtl/key_conditioner_pkg.sv
// Shared types for the key input conditioner: arbiter states, synchroniser depth
// and a one-hot test used by the arbiter.
package key_conditioner_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HELD  = 2'd1,
      CHORD = 2'd2
   } arb_state_t;

   // Callers zero-extend their vector to 32 bits; exactly one bit set returns 1.
   function automatic logic is_one_hot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/key_input_conditioner_if.sv
// Pin-side and lock-FSM-side signals of the key input conditioner.
interface key_input_conditioner_if #(
   parameter int KEY_WIDTH = 4
);
   // No back-pressure: rawKey is a free-running level; key is a registered level
   // that is zero or one-hot, and keyPressed is a single-cycle strobe that is
   // valid only in the cycle key leaves zero. The consumer is always ready.
   logic [KEY_WIDTH-1:0] rawKey;
   logic [KEY_WIDTH-1:0] key;
   logic                 keyPressed;
   logic                 chordError;

   modport master (output rawKey, input key, keyPressed, chordError);
   modport slave  (input rawKey, output key, keyPressed, chordError);
endinterface

// File: rtl/key_input_conditioner_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and accepted level.
module debounce_channel
   import key_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic i_raw,
   output logic o_stable
);

   localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_stable;
   logic [COUNTER_WIDTH-1:0] r_cnt;
   logic                   w_sample;

   assign w_sample = r_sync[SYNC_STAGES-1];
   assign o_stable = r_stable;

   // Any return to the accepted level clears the count, so a bounce restarts it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync   <= '0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         if (w_sample == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= w_sample;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_input_conditioner.sv
// Debounces each button and presents at most one held button as a one-hot key.
// Build option: KEY_ACTIVE_LOW_EN inverts rawKey ahead of the synchronisers.
module key_input_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int CLOCK_FREQ       = 50000000,
   parameter int DEBOUNCE_TIME_MS = 20,
   parameter int DEBOUNCE_CYCLES  = CLOCK_FREQ / 1000 * DEBOUNCE_TIME_MS,
   parameter int COUNTER_WIDTH    = $clog2(DEBOUNCE_CYCLES + 1),
   parameter int KEY_WIDTH        = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   key_input_conditioner_if.slave  bus,
   output arb_state_t              o_dbg_state
);

   logic [KEY_WIDTH-1:0] w_raw;
   logic [KEY_WIDTH-1:0] w_stable;

   arb_state_t           r_state;
   logic [KEY_WIDTH-1:0] r_key;
   logic                 r_key_pressed;
   logic                 r_chord_error;

`ifdef KEY_ACTIVE_LOW_EN
   assign w_raw = ~bus.rawKey;
`else
   assign w_raw = bus.rawKey;
`endif

   for (genvar gi = 0; gi < KEY_WIDTH; gi++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .COUNTER_WIDTH   (COUNTER_WIDTH)
      ) u_chan (
         .clock    (clock),
         .reset    (reset),
         .i_raw    (w_raw[gi]),
         .o_stable (w_stable[gi])
      );
   end

   // A chord only clears once every button is released, so a leftover single
   // button can never produce a second keyPressed.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_key         <= '0;
         r_key_pressed <= 1'b0;
         r_chord_error <= 1'b0;
      end else begin
         r_key_pressed <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_stable == '0) begin
                  r_key         <= '0;
                  r_chord_error <= 1'b0;
               end else if (is_one_hot(32'(w_stable))) begin
                  r_state       <= HELD;
                  r_key         <= w_stable;
                  r_key_pressed <= 1'b1;
               end else begin
                  r_state       <= CHORD;
                  r_key         <= '0;
                  r_chord_error <= 1'b1;
               end
            end
            HELD: begin
               if (w_stable == r_key) begin
                  r_state <= HELD;
               end else if (w_stable == '0) begin
                  r_state <= IDLE;
                  r_key   <= '0;
               end else begin
                  r_state       <= CHORD;
                  r_key         <= '0;
                  r_chord_error <= 1'b1;
               end
            end
            CHORD: begin
               r_key <= '0;
               if (w_stable == '0) begin
                  r_state       <= IDLE;
                  r_chord_error <= 1'b0;
               end else begin
                  r_chord_error <= 1'b1;
               end
            end
            default: begin
               r_state       <= IDLE;
               r_key         <= '0;
               r_chord_error <= 1'b0;
            end
         endcase
      end
   end

   assign bus.key        = r_key;
   assign bus.keyPressed = r_key_pressed;
   assign bus.chordError = r_chord_error;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DEBOUNCE_CYCLES=4, active-high keys.
module tb_key_input_conditioner;
   import key_conditioner_pkg::*;

   logic       clock;
   logic       reset;
   arb_state_t dbg_state;
   int         checks;
   int         failures;
   int         kp_count;

   key_input_conditioner_if #(.KEY_WIDTH(4)) bus ();

   key_input_conditioner #(
      .CLOCK_FREQ       (50000000),
      .DEBOUNCE_TIME_MS (20),
      .DEBOUNCE_CYCLES  (4),
      .KEY_WIDTH        (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // keyPressed is high for one full period, so the falling edge sees each pulse once
   initial kp_count = 0;
   always @(negedge clock) if (bus.keyPressed === 1'b1) kp_count++;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.rawKey = 4'b0000;
      step(2);
      checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL reset_key got=%b exp=0000", bus.key); end
      checks++; if (bus.keyPressed !== 1'b0) begin failures++; $display("FAIL reset_kp got=%b exp=0", bus.keyPressed); end
      checks++; if (bus.chordError !== 1'b0) begin failures++; $display("FAIL reset_chord got=%b exp=0", bus.chordError); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      reset = 1'b0;
      step(2);
   endtask

   task automatic test_single_press;
      int kp0;
      kp0 = kp_count;
      bus.rawKey = 4'b0010;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL press_early edge=%0d got=%b exp=0000", i, bus.key); end
      end
      step(1);
      checks++; if (bus.key !== 4'b0010) begin failures++; $display("FAIL press_key got=%b exp=0010", bus.key); end
      checks++; if (bus.keyPressed !== 1'b1) begin failures++; $display("FAIL press_kp got=%b exp=1", bus.keyPressed); end
      step(1);
      checks++; if (bus.keyPressed !== 1'b0) begin failures++; $display("FAIL press_kp_width got=%b exp=0", bus.keyPressed); end
      checks++; if (bus.key !== 4'b0010) begin failures++; $display("FAIL press_hold got=%b exp=0010", bus.key); end
      bus.rawKey = 4'b0000;
      step(7);
      checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL press_release got=%b exp=0000", bus.key); end
      checks++; if (kp_count - kp0 !== 1) begin failures++; $display("FAIL press_kp_count got=%0d exp=1", kp_count - kp0); end
      step(2);
   endtask

   task automatic test_bounce;
      int kp0;
      kp0 = kp_count;
      for (int i = 0; i < 10; i++) begin
         bus.rawKey = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         for (int j = 0; j < 2; j++) begin
            step(1);
            checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL bounce_quiet half=%0d got=%b exp=0000", i, bus.key); end
         end
      end
      bus.rawKey = 4'b0001;
      step(6);
      checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL bounce_early got=%b exp=0000", bus.key); end
      step(1);
      checks++; if (bus.key !== 4'b0001) begin failures++; $display("FAIL bounce_settle got=%b exp=0001", bus.key); end
      step(1);
      checks++; if (kp_count - kp0 !== 1) begin failures++; $display("FAIL bounce_kp_count got=%0d exp=1", kp_count - kp0); end
      bus.rawKey = 4'b0000;
      step(9);
   endtask

   task automatic test_chord_add;
      int kp0;
      kp0 = kp_count;
      bus.rawKey = 4'b0001;
      step(7);
      checks++; if (bus.key !== 4'b0001) begin failures++; $display("FAIL chord_first got=%b exp=0001", bus.key); end
      bus.rawKey = 4'b0101;
      step(6);
      checks++; if (bus.key !== 4'b0001) begin failures++; $display("FAIL chord_before got=%b exp=0001", bus.key); end
      step(1);
      checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL chord_key got=%b exp=0000", bus.key); end
      checks++; if (bus.chordError !== 1'b1) begin failures++; $display("FAIL chord_err got=%b exp=1", bus.chordError); end
      bus.rawKey = 4'b0001;
      step(10);
      checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL chord_partial_key got=%b exp=0000", bus.key); end
      checks++; if (dbg_state !== CHORD) begin failures++; $display("FAIL chord_partial_state got=%0d exp=2", dbg_state); end
      bus.rawKey = 4'b0000;
      step(7);
      checks++; if (bus.chordError !== 1'b0) begin failures++; $display("FAIL chord_exit_err got=%b exp=0", bus.chordError); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL chord_exit_state got=%0d exp=0", dbg_state); end
      checks++; if (kp_count - kp0 !== 1) begin failures++; $display("FAIL chord_kp_count got=%0d exp=1", kp_count - kp0); end
      step(2);
   endtask

   task automatic test_simultaneous;
      int kp0;
      kp0 = kp_count;
      bus.rawKey = 4'b1100;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL simul_key edge=%0d got=%b exp=0000", i, bus.key); end
         if (i == 7) begin
            checks++; if (bus.chordError !== 1'b1) begin failures++; $display("FAIL simul_err got=%b exp=1", bus.chordError); end
         end
      end
      bus.rawKey = 4'b0000;
      step(8);
      checks++; if (bus.chordError !== 1'b0) begin failures++; $display("FAIL simul_exit got=%b exp=0", bus.chordError); end
      checks++; if (kp_count - kp0 !== 0) begin failures++; $display("FAIL simul_kp_count got=%0d exp=0", kp_count - kp0); end
   endtask

   task automatic test_reset_mid_press;
      bus.rawKey = 4'b1000;
      step(7);
      checks++; if (bus.key !== 4'b1000) begin failures++; $display("FAIL rst_mid_before got=%b exp=1000", bus.key); end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL rst_mid_clear got=%b exp=0000", bus.key); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", dbg_state); end
      for (int i = 1; i <= 6; i++) begin
         step(1);
         checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL rst_mid_wait edge=%0d got=%b exp=0000", i, bus.key); end
      end
      step(1);
      checks++; if (bus.key !== 4'b1000) begin failures++; $display("FAIL rst_mid_return got=%b exp=1000", bus.key); end
      checks++; if (bus.keyPressed !== 1'b1) begin failures++; $display("FAIL rst_mid_kp got=%b exp=1", bus.keyPressed); end
      bus.rawKey = 4'b0000;
      step(9);
   endtask

   task automatic test_release_bounce;
      int kp0;
      bus.rawKey = 4'b0100;
      step(7);
      checks++; if (bus.key !== 4'b0100) begin failures++; $display("FAIL rel_hold got=%b exp=0100", bus.key); end
      step(1);
      kp0 = kp_count;
      bus.rawKey = 4'b0000;
      step(2);
      bus.rawKey = 4'b0100;
      step(2);
      checks++; if (bus.key !== 4'b0100) begin failures++; $display("FAIL rel_bounce got=%b exp=0100", bus.key); end
      bus.rawKey = 4'b0000;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         checks++; if (bus.key !== 4'b0100) begin failures++; $display("FAIL rel_wait edge=%0d got=%b exp=0100", i, bus.key); end
      end
      step(1);
      checks++; if (bus.key !== 4'b0000) begin failures++; $display("FAIL rel_drop got=%b exp=0000", bus.key); end
      step(4);
      checks++; if (kp_count - kp0 !== 0) begin failures++; $display("FAIL rel_kp_count got=%0d exp=0", kp_count - kp0); end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rel_state got=%0d exp=0", dbg_state); end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      bus.rawKey = 4'b0000;
      test_reset();
      test_single_press();
      test_bounce();
      test_chord_add();
      test_simultaneous();
      test_reset_mid_press();
      test_release_bounce();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
